serdes_tx_scheduler: RTL and testbench

//  Transmit-side sequencer for the 8b/10b encoder and 10-bit serializer.

---
 rtl/serdes_tx_scheduler.sv | 107 ++++++++++
 tb/tb_serdes_tx_scheduler.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serdes_tx_scheduler.sv
// Transmit sequencer for the 8b/10b encoder + 10-bit serializer: slot timing,
// link training, valid/ready user intake, idle fill and drain on link disable.
module serdes_tx_scheduler #(
   parameter int unsigned FRAME_LEN   = 10,
   parameter int unsigned TRAIN_WORDS = 16,
   parameter logic [7:0]  TRAIN_BYTE  = 8'h4A,
   parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       link_en,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic [7:0] enc_data,
   output logic       enc_ser_en,
   output logic       ser_load,
   output logic       link_up,
   output logic       tx_active,
   output logic       idle_fill
);
   localparam int unsigned CW  = $clog2(FRAME_LEN);
   localparam int unsigned TCW = $clog2(TRAIN_WORDS + 1);
   localparam logic [CW-1:0]  ISSUE = CW'(FRAME_LEN - 2);
   localparam logic [CW-1:0]  LOAD  = CW'(FRAME_LEN - 1);
   localparam logic [TCW-1:0] TW    = TCW'(TRAIN_WORDS);

   typedef enum logic [1:0] {OFF, TRAIN, DATA, DRAIN} state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_nxt;
   logic [TCW-1:0] train_cnt;
   logic [TCW-1:0] train_inc;
   logic           load_q;
   logic           at_issue;
   logic           sending;

   assign cnt_nxt   = (cnt == LOAD) ? '0 : cnt + 1'b1;
   assign train_inc = (train_cnt == TW) ? train_cnt : train_cnt + 1'b1;

   // Strobe/handshake decode; link_en is only consulted at the issue slot.
   assign at_issue   = (cnt == ISSUE);
   assign sending    = (state == TRAIN) || (state == DATA);
   assign enc_ser_en = sending && at_issue && link_en;
   assign in_ready   = (state == DATA) && at_issue && link_en;
   assign idle_fill  = in_ready && !in_valid;
   assign link_up    = (state == DATA);
   assign tx_active  = (state != OFF);
   assign ser_load   = load_q;

   always_comb begin
      enc_data = IDLE_BYTE;
      if (enc_ser_en) begin
         if (state == TRAIN)
            enc_data = TRAIN_BYTE;
         else if (in_valid)
            enc_data = in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= OFF;
         cnt       <= '0;
         train_cnt <= '0;
         load_q    <= 1'b0;
      end else begin
         // Encoder output lands one cycle after its strobe, i.e. in the LOAD slot.
         load_q <= enc_ser_en;
         case (state)
            OFF: begin
               cnt <= '0;
               if (link_en) begin
                  state     <= TRAIN;
                  train_cnt <= '0;
               end
            end
            TRAIN: begin
               cnt <= cnt_nxt;
               if (at_issue && !link_en)
                  state <= DRAIN;
               if (cnt == LOAD && load_q) begin
                  train_cnt <= train_inc;
                  if (train_inc >= TW)
                     state <= DATA;
               end
            end
            DATA: begin
               cnt <= cnt_nxt;
               if (at_issue && !link_en)
                  state <= DRAIN;
            end
            DRAIN: begin
               cnt <= cnt_nxt;
               if (cnt == LOAD)
                  state <= OFF;
            end
            default: begin
               state <= OFF;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serdes_tx_scheduler.sv
// Random + targeted stimulus against a slot-arithmetic reference model; a
// negedge monitor pops the scoreboard queues as the DUT presents its outputs.
module tb_serdes_tx_scheduler;
   localparam int F  = 10;
   localparam int TW = 16;
   localparam logic [7:0] TRN_B = 8'h4A;
   localparam logic [7:0] IDL_B = 8'h00;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       link_en = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready, enc_ser_en, ser_load, link_up, tx_active, idle_fill;
   logic [7:0] enc_data;

   always #5 clk = ~clk;

   serdes_tx_scheduler #(
      .FRAME_LEN(F), .TRAIN_WORDS(TW), .TRAIN_BYTE(TRN_B), .IDLE_BYTE(IDL_B)
   ) dut (
      .clk(clk), .rst_n(rst_n), .link_en(link_en), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .enc_data(enc_data),
      .enc_ser_en(enc_ser_en), .ser_load(ser_load), .link_up(link_up),
      .tx_active(tx_active), .idle_fill(idle_fill)
   );

   typedef struct { bit en; bit load; bit ready; bit idle; bit up; bit act; logic [7:0] data; } stat_t;
   typedef struct { int cyc; logic [7:0] data; bit idle; } word_t;

   stat_t stq[$];
   word_t wq[$];
   int    lq[$];
   int    n_chk = 0;
   int    n_fail = 0;
   int    cyc = 0;

   // Model: a session starts at m_t0; cycle k of it is phase k%F of slot k/F,
   // and the first TW slots are training.
   bit m_valid = 0, m_on = 0, m_drain = 0, m_prev_en = 0;
   int m_t0 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic model(input bit le, input bit iv, input logic [7:0] id, input bit rn);
      stat_t s;
      int k, ph, slot;
      bit trn, last;
      s = '{default: 0};
      s.data = IDL_B;
      last = 0;
      if (m_on) begin
         k = cyc - m_t0; ph = k % F; slot = k / F; trn = (slot < TW);
         s.act = 1;
         s.up  = !trn && !m_drain;
         if (ph == F-2) begin
            if (le) begin
               s.en    = 1;
               s.data  = trn ? TRN_B : (iv ? id : IDL_B);
               s.ready = !trn;
               s.idle  = !trn && !iv;
            end else
               m_drain = 1;
         end
         if (ph == F-1) begin
            s.load = m_prev_en;
            last   = m_drain;
         end
      end
      if (m_valid) begin
         stq.push_back(s);
         if (s.en)   wq.push_back('{cyc, s.data, s.idle});
         if (s.load) lq.push_back(cyc);
      end
      m_prev_en = s.en;
      if (!rn) begin
         m_on = 0; m_drain = 0; m_prev_en = 0; m_valid = 1;
      end else if (!m_on) begin
         if (le && m_valid) begin m_on = 1; m_t0 = cyc + 1; m_drain = 0; end
      end else if (last) begin
         m_on = 0; m_drain = 0;
      end
   endtask

   task automatic tick(input bit le, input bit iv, input logic [7:0] id, input bit rn);
      @(posedge clk); #1;
      link_en = le; in_valid = iv; in_data = id; rst_n = rn;
      cyc++;
      model(le, iv, id, rn);
   endtask

   function automatic int nph();
      return m_on ? (cyc + 1 - m_t0) % F : -1;
   endfunction

   stat_t mon_s;
   word_t mon_w;
   int    mon_l;
   always @(negedge clk) begin
      if (stq.size() > 0) begin
         mon_s = stq.pop_front();
         chk("enc_ser_en", 32'(enc_ser_en), 32'(mon_s.en));
         chk("ser_load",   32'(ser_load),   32'(mon_s.load));
         chk("in_ready",   32'(in_ready),   32'(mon_s.ready));
         chk("idle_fill",  32'(idle_fill),  32'(mon_s.idle));
         chk("link_up",    32'(link_up),    32'(mon_s.up));
         chk("tx_active",  32'(tx_active),  32'(mon_s.act));
         if (mon_s.en || !mon_s.act) chk("enc_data", 32'(enc_data), 32'(mon_s.data));
         if (enc_ser_en === 1'b1) begin
            chk("strobe_expected", 32'(wq.size() > 0), 32'(1));
            if (wq.size() > 0) begin
               mon_w = wq.pop_front();
               chk("word_cycle", 32'(cyc), 32'(mon_w.cyc));
               chk("word_data",  32'(enc_data), 32'(mon_w.data));
               chk("word_idle",  32'(idle_fill), 32'(mon_w.idle));
            end
         end
         if (ser_load === 1'b1) begin
            chk("load_expected", 32'(lq.size() > 0), 32'(1));
            if (lq.size() > 0) begin
               mon_l = lq.pop_front();
               chk("load_cycle", 32'(cyc), 32'(mon_l));
            end
         end
      end
   end

   int unsigned run, p;
   int guard;
   initial begin
      repeat (2) tick(0, 0, 8'h00, 0);
      // Bring-up: 16 training words then DATA with nothing offered
      repeat (180) tick(1, 0, 8'h00, 1);
      // Held valid with a constant byte: one accept per slot
      repeat (45) tick(1, 1, 8'hA5, 1);
      repeat (150) tick(1, 1'($urandom_range(0, 1)), 8'($urandom), 1);
      // Drop link_en mid-slot (cnt 3), then re-enable and retrain
      guard = 0;
      while (nph() != 3 && guard < 100) begin tick(1, 1, 8'($urandom), 1); guard++; end
      repeat (14) tick(0, 1, 8'($urandom), 1);
      repeat (200) tick(1, 1'($urandom_range(0, 1)), 8'($urandom), 1);
      // Drop exactly at ISSUE, pulse link_en during the DRAIN cycle, then stay off
      guard = 0;
      while (nph() != F-2 && guard < 100) begin tick(1, 1, 8'($urandom), 1); guard++; end
      tick(0, 1, 8'h11, 1);
      tick(1, 1, 8'h22, 1);
      repeat (15) tick(0, 0, 8'h00, 1);
      // Reset during training at cnt 5 with 7 words sent, then full retrain
      guard = 0;
      while (!(m_on && (cyc + 1 - m_t0) == 7*F + 5) && guard < 200) begin tick(1, 0, 8'h00, 1); guard++; end
      tick(1, 0, 8'h00, 0);
      repeat (200) tick(1, 1'($urandom_range(0, 1)), 8'($urandom), 1);
      // Random sessions with occasional resets and stray link_en pulses while off
      repeat (25) begin
         run = $urandom_range(30, 400);
         p   = $urandom_range(0, 4);
         for (int i = 0; i < int'(run); i++)
            tick(1, 1'($urandom_range(0, 3) < p), 8'($urandom), 1'($urandom_range(0, 299) != 0));
         repeat ($urandom_range(1, 25))
            tick(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), 8'($urandom), 1);
      end
      repeat (3) tick(0, 0, 8'h00, 1);
      @(negedge clk); #1;
      chk("word_q_drained", 32'(wq.size()), 32'(0));
      chk("load_q_drained", 32'(lq.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
